// File: rtl/serial_line_router_pkg.sv
// Shared types and constants for the serial line router: FSM states, default
// timing constants and the idle level of the serial line.
package serial_router_pkg;

  typedef enum logic [1:0] {
    ROUTE   = 2'd0,
    PENDING = 2'd1,
    SWITCH  = 2'd2
  } state_e;

  localparam int DEF_IDLE_CYCLES  = 16;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_BREAK_CYCLES = 1024;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_line_router_line_idle_detect.sv
// Input synchroniser plus saturating idle counter (and, with
// SERIAL_LINE_ROUTER_BREAK_DETECT_EN, a saturating low counter for breaks).
module line_idle_detect
  import serial_router_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  ,
  parameter int BREAK_CYCLES = DEF_BREAK_CYCLES
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic in_s,
  output logic line_idle
`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  ,
  output logic break_det
`endif
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [IDLE_W-1:0]      idle_cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours (a true shift chain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{LINE_IDLE}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in};
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                idle_cnt <= '0;
    else if (in_s != LINE_IDLE) idle_cnt <= '0;
    else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
  end

  assign line_idle = (idle_cnt == IDLE_MAX);

`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  localparam int LOW_W = $clog2(BREAK_CYCLES + 1);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(BREAK_CYCLES);

  logic [LOW_W-1:0] low_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 low_cnt <= '0;
    else if (in_s == LINE_IDLE) low_cnt <= '0;
    else if (low_cnt != LOW_MAX) low_cnt <= low_cnt + 1'b1;
  end

  assign break_det = (low_cnt == LOW_MAX);
`endif

endmodule

// File: rtl/serial_line_router.sv
// N-channel router for an idle-high serial line; channel changes only take
// effect once the line is idle. Optional break detection: SERIAL_LINE_ROUTER_BREAK_DETECT_EN.
module serial_line_router
  import serial_router_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = $clog2(NUM_CH),
  parameter int IDLE_CYCLES  = DEF_IDLE_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int BREAK_CYCLES = DEF_BREAK_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic [NUM_CH-1:0] out,
  output logic [SEL_W-1:0]  active_sel,
  output logic              busy,
  output logic              switch_done,
  output logic              sel_err,
  output logic              break_err
);

  if (NUM_CH < 2 || NUM_CH > 16 || IDLE_CYCLES < 1 || IDLE_CYCLES > 255 ||
      SYNC_STAGES < 2 || SYNC_STAGES > 3 || BREAK_CYCLES < 1) begin : g_param_check
    $error("serial_line_router: parameter out of range");
  end

  localparam logic [SEL_W:0] NUM_CH_X = (SEL_W + 1)'(NUM_CH);

  logic              in_s;
  logic              line_idle;
  logic              break_q;
  state_e            state, state_n;
  logic [SEL_W-1:0]  active_q, pend_q;
  logic              accept, same_req, bad_req;
  logic              done_q, err_q;
  logic [NUM_CH-1:0] out_d, out_q;

`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  logic break_det;
`endif

  line_idle_detect #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
    ,
    .BREAK_CYCLES(BREAK_CYCLES)
`endif
  ) u_idle (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_s     (in_s),
    .line_idle(line_idle)
`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
    ,
    .break_det(break_det)
`endif
  );

  // NOTE: every variable driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    same_req = 1'b0;
    bad_req  = 1'b0;
    unique case (state)
      ROUTE: begin
        if (sel_valid) begin
          if ({1'b0, sel_req} >= NUM_CH_X) begin
            bad_req = 1'b1;
          end else if (sel_req == active_q) begin
            same_req = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = PENDING;
          end
        end
      end
      PENDING: if (line_idle || !enable) state_n = SWITCH;
      SWITCH:  state_n = ROUTE;
      default: state_n = ROUTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ROUTE;
      active_q <= '0;
      pend_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == SWITCH) || same_req;
      err_q  <= bad_req;
      if (accept)          pend_q   <= sel_req;
      if (state == SWITCH) active_q <= pend_q;
    end
  end

`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  // Break holds until the line has been idle again for a full idle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         break_q <= 1'b0;
    else if (break_det) break_q <= 1'b1;
    else if (line_idle) break_q <= 1'b0;
  end
`else
  assign break_q = 1'b0;
`endif

  // The switch cycle blanks every output so the old and new channel never overlap.
  always_comb begin
    out_d = {NUM_CH{LINE_IDLE}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable && state != SWITCH && !break_q && active_q == SEL_W'(i)) out_d[i] = in_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= {NUM_CH{LINE_IDLE}};
    else        out_q <= out_d;
  end

  assign out         = out_q;
  assign active_sel  = active_q;
  assign sel_ready   = (state == ROUTE);
  assign busy        = (state != ROUTE);
  assign switch_done = done_q;
  assign sel_err     = err_q;
  assign break_err   = break_q;

endmodule

// File: tb/tb_serial_line_router.sv
// Self-checking bench: directed scenarios plus random frames/requests, every cycle
// compared against a queue-based behavioural model of the routing rules.
module tb_serial_line_router;

  localparam int NCH  = 4;
  localparam int SW   = 2;
  localparam int IDLE = 16;
  localparam int BRK  = 64;
`ifdef SERIAL_LINE_ROUTER_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n, enable, in, sel_valid;
  logic [SW-1:0]  sel_req;
  logic           sel_ready, busy, switch_done, sel_err, break_err;
  logic [NCH-1:0] out;
  logic [SW-1:0]  active_sel;

  logic       sel_valid3;
  logic [1:0] sel_req3, active_sel3;
  logic       sel_ready3, busy3, switch_done3, sel_err3, break_err3;
  logic [2:0] out3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_line_router #(.NUM_CH(NCH), .BREAK_CYCLES(BRK)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in),
    .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .out(out), .active_sel(active_sel), .busy(busy),
    .switch_done(switch_done), .sel_err(sel_err), .break_err(break_err)
  );

  serial_line_router #(.NUM_CH(3), .BREAK_CYCLES(BRK)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in),
    .sel_req(sel_req3), .sel_valid(sel_valid3), .sel_ready(sel_ready3),
    .out(out3), .active_sel(active_sel3), .busy(busy3),
    .switch_done(switch_done3), .sel_err(sel_err3), .break_err(break_err3)
  );

  // Behavioural model: line history as a queue of synchronised samples,
  // routing described by "pending" / "switching" flags.
  bit             m_sync0;
  bit             s_q[$];
  int             m_act, m_tgt;
  bit             m_pend, m_sw, m_done, m_err, m_brk;
  logic [NCH-1:0] m_out;

  // True when the n synchronised samples preceding the newest one all equal v.
  function automatic bit run_of(input bit v, input int n);
    if (s_q.size() - 1 < n) return 1'b0;
    for (int k = 0; k < n; k++) if (s_q[s_q.size() - 2 - k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_sync0 = 1'b1;
    s_q.delete();
    s_q.push_back(1'b1);
    m_act = 0; m_tgt = 0;
    m_pend = 0; m_sw = 0; m_done = 0; m_err = 0; m_brk = 0;
    m_out = '1;
  endtask

  task automatic model_edge();
    bit idle_pre, low_pre, s_now;
    idle_pre = run_of(1'b1, IDLE);
    low_pre  = run_of(1'b0, BRK);
    s_now    = s_q[s_q.size() - 1];
    for (int i = 0; i < NCH; i++)
      m_out[i] = (enable && !m_sw && !m_brk && i == m_act) ? s_now : 1'b1;
    if (BRK_EN) m_brk = low_pre || (m_brk && !idle_pre);
    m_done = 0;
    m_err  = 0;
    if (m_sw) begin
      m_act = m_tgt; m_sw = 0; m_done = 1;
    end else if (m_pend) begin
      if (idle_pre || !enable) begin m_pend = 0; m_sw = 1; end
    end else if (sel_valid) begin
      if (int'(sel_req) >= NCH)     m_err = 1;
      else if (int'(sel_req) == m_act) m_done = 1;
      else begin m_pend = 1; m_tgt = int'(sel_req); end
    end
    s_q.push_back(m_sync0);
    m_sync0 = in;
    if (s_q.size() > 200) void'(s_q.pop_front());
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out",         32'(out),         32'(m_out));
    check("active_sel",  32'(active_sel),  m_act);
    check("sel_ready",   32'(sel_ready),   32'(!(m_pend || m_sw)));
    check("busy",        32'(busy),        32'(m_pend || m_sw));
    check("switch_done", 32'(switch_done), 32'(m_done));
    check("sel_err",     32'(sel_err),     32'(m_err));
    check("break_err",   32'(break_err),   32'(m_brk));
  endtask

  // One clock: model the edge, compare after it, return at the next negedge.
  // A requester holds sel_valid until the router is in a state that takes it.
  task automatic tick();
    bit take;
    take = sel_valid && !m_pend && !m_sw;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
    if (take) sel_valid = 1'b0;
  endtask

  task automatic maybe_req();
    if (!sel_valid && $urandom_range(0, 15) == 0) begin
      sel_valid = 1'b1;
      sel_req   = SW'($urandom_range(0, NCH - 1));
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    in = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (rnd) maybe_req();
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bl, input int req_bit,
                           input int req_ch, input bit rnd);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      in = frame[k];
      if (k == req_bit) begin sel_valid = 1'b1; sel_req = SW'(req_ch); end
      for (int c = 0; c < bl; c++) begin
        if (rnd) maybe_req();
        tick();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] frame;
    rst_n = 1'b0; enable = 1'b1; in = 1'b1; sel_valid = 1'b0; sel_req = '0;
    sel_valid3 = 1'b0; sel_req3 = '0;
    model_reset();
    #12;
    check_all();
    check("rst_out_const", 32'(out), 32'hF);
    check("rst_out3",      32'(out3), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: a one-cycle low pulse on in reaches out[0] three edges later.
    idle(4, 1'b0);
    in = 1'b0; tick();
    in = 1'b1; tick();
    check("lat_edge2", 32'(out), 32'hF);
    tick();
    check("lat_edge3", 32'(out), 32'hE);
    tick();
    check("lat_edge4", 32'(out), 32'hF);

    // Request ch2 mid-frame (0x55, 8 clk/bit): switch waits for stop + idle window.
    idle(20, 1'b0);
    send_byte(8'h55, 8, 2, 2, 1'b0);
    check("busy_after_frame", 32'(busy), 32'h1);
    check("ch0_still", 32'(active_sel), 32'h0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (switch_done) begin n = c; break; end
    end
    check("switch_wait", n, 12);
    check("active_ch2", 32'(active_sel), 32'h2);
    idle(4, 1'b0);
    send_byte(8'hA3, 4, -1, 0, 1'b0);

    // Request ch1 with the line idle: minimum switch latency of two cycles.
    idle(24, 1'b0);
    sel_valid = 1'b1; sel_req = 2'd1;
    tick();
    check("fast_busy", 32'(busy), 32'h1);
    check("fast_ready", 32'(sel_ready), 32'h0);
    tick();
    check("fast_mid_active", 32'(active_sel), 32'h2);
    tick();
    check("fast_done", 32'(switch_done), 32'h1);
    check("fast_active", 32'(active_sel), 32'h1);
    check("fast_out", 32'(out), 32'hF);
    tick();
    check("fast_done_clr", 32'(switch_done), 32'h0);

    // Same-channel request acknowledges without switching.
    sel_valid = 1'b1; sel_req = 2'd1;
    tick();
    check("same_done", 32'(switch_done), 32'h1);
    check("same_busy", 32'(busy), 32'h0);
    tick();

    // Out-of-range request on the 3-channel instance.
    sel_valid3 = 1'b1; sel_req3 = 2'd3;
    tick();
    sel_valid3 = 1'b0;
    check("err3_pulse", 32'(sel_err3), 32'h1);
    check("err3_active", 32'(active_sel3), 32'h0);
    check("err3_ready", 32'(sel_ready3), 32'h1);
    tick();
    check("err3_clear", 32'(sel_err3), 32'h0);

    // enable dropped mid-frame with a request pending: switch without idle wait.
    frame = {1'b1, 8'h3C, 1'b0};
    in = frame[0];
    repeat (3) tick();
    sel_valid = 1'b1; sel_req = 2'd3;
    tick();
    enable = 1'b0;
    tick();
    check("en_out_high", 32'(out), 32'hF);
    check("en_busy", 32'(busy), 32'h1);
    tick();
    check("en_done", 32'(switch_done), 32'h1);
    check("en_active", 32'(active_sel), 32'h3);
    for (int k = 1; k < 10; k++) begin
      in = frame[k];
      repeat (4) tick();
    end
    enable = 1'b1;
    idle(20, 1'b0);
    in = 1'b0; tick();
    in = 1'b1; tick(); tick();
    check("en_new_route", 32'(out), 32'h7);
    idle(4, 1'b0);

    // Long low: break flag (when built in), then recovery after an idle window.
    in = 1'b0;
    repeat (70) tick();
    check("brk_set", 32'(break_err), 32'(BRK_EN));
    if (BRK_EN) check("brk_out", 32'(out), 32'hF);
    in = 1'b1;
    repeat (20) tick();
    check("brk_clear", 32'(break_err), 32'h0);
    send_byte(8'h96, 3, -1, 0, 1'b0);

    // Random frames, bit lengths, gaps, requests and enable windows.
    for (int f = 0; f < 60; f++) begin
      enable = ($urandom_range(0, 7) != 0);
      send_byte(8'($urandom), $urandom_range(1, 6), -1, 0, 1'b1);
      idle($urandom_range(0, 24), 1'b1);
    end
    enable = 1'b1;
    for (int c = 0; c < 60 && (sel_valid || busy); c++) tick();
    check("drain_idle", 32'(busy), 32'h0);

    // Reset in the middle of a pending switch discards it.
    in = 1'b0;
    repeat (3) tick();
    sel_valid = 1'b1; sel_req = SW'((m_act + 1) % NCH);
    tick();
    check("rst_pend_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_active", 32'(active_sel), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_ready", 32'(sel_ready), 32'h1);
    check("rst_mid_out", 32'(out), 32'hF);
    @(negedge clk);
    rst_n = 1'b1; sel_valid = 1'b0; in = 1'b1;
    idle(24, 1'b0);
    check("rst_no_switch", 32'(active_sel), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
